agc_gain_scaler: RTL and testbench
==================================

Name: agc_gain_scaler

Overview:
Next-generation digital gain/scaling stage for the SDR receive path, placed after the decimation chain and ahead of the FFT/packetiser.
- Processes NUM_CH packed channels per sample (I/Q by default) with fractional gain, a signed power-of-two shift, rounding and symmetric saturation.
- Uses a 3-stage pipeline with valid/ready backpressure.
- Has an optional closed-loop AGC that adjusts gain once per window from the measured output peak.
- Manual mode reproduces fixed-gain behaviour under RP2040 register control.

Parameters:
- DATA_WIDTH, 16, sample width per channel, signed two's complement.
- NUM_CH, 2, channels packed per beat; channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- GAIN_WIDTH, 12, unsigned gain word width.
- GAIN_FRAC, 8, fractional bits of gain; unity = 2^GAIN_FRAC.
- WIN_LOG2, 10, AGC measurement window of 2^WIN_LOG2 output beats.
- AGC_STEP, 4, AGC step = max(gain >> AGC_STEP, 1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- s_data  in  NUM_CH*DATA_WIDTH  input samples
- s_valid  in  1  input valid
- s_ready  out  1  input ready
- m_data  out  NUM_CH*DATA_WIDTH  scaled samples
- m_valid  out  1  output valid
- m_ready  in  1  downstream ready
- agc_enable  in  1  1 = AGC loop, 0 = manual gain
- manual_gain  in  GAIN_WIDTH  manual gain, unsigned Q(GAIN_WIDTH-GAIN_FRAC).GAIN_FRAC
- shift_ctrl  in  4  signed shift, -8..+7; positive = left
- target_level  in  DATA_WIDTH-1  AGC target peak magnitude
- hysteresis  in  DATA_WIDTH-1  AGC dead band half-width
- sat_clear  in  1  synchronous clear of sat_count
- gain_cur  out  GAIN_WIDTH  gain currently applied at stage 1
- sat_count  out  16  saturated output beats, saturating counter

Behaviour:
- Reset (async assert, sync deassert assumed upstream):
  - m_valid=0, m_data=0, sat_count=0.
  - gain_cur=2^GAIN_FRAC, AGC state=MANUAL, peak/window counter=0.
  - s_ready=1.
- Pipeline enable: en = !m_valid_s3 || m_ready; s_ready = en (combinational). When en=0 all stages hold; no beat is lost, duplicated or reordered.
- S1: on s_valid && s_ready, register s_data, gain_cur and shift_ctrl. Each beat carries its own gain/shift through the pipe; control changes never affect in-flight beats.
- S2: per channel, product = signed(sample) × zero-extended gain; width DATA_WIDTH+GAIN_WIDTH+1.
- S3, scaling:
  - net = GAIN_FRAC − shift_ctrl.
  - If net>0: add 2^(net−1), then arithmetic right shift by net (round half up).
  - If net<=0: left shift by −net, computed at full width before saturation.
- S3, saturation:
  - Clamp to ±(2^(DATA_WIDTH−1)−1); −2^(DATA_WIDTH−1) is never output.
  - A beat is saturated if any channel clamped.
- Latency: 3 cycles from input handshake to m_valid with m_ready held high; throughput 1 beat/cycle.
- sat_count:
  - +1 on each accepted (m_valid && m_ready) saturated beat; holds at 0xFFFF.
  - sat_clear wins over increment except when both occur on a saturated accepted beat, in which case the result is 1.
- AGC FSM:
  - MANUAL: gain_cur ← manual_gain every cycle. agc_enable=1 → MEASURE with peak=0, cnt=0; gain_cur starts from its current value.
  - MEASURE: on each accepted output beat, peak ← max(peak, |ch| over all channels), sat_seen |= saturated, cnt++. Accept with cnt = 2^WIN_LOG2−1 → ADJUST.
  - ADJUST (one cycle), with lo = max(target_level−hysteresis, 0) and hi = min(target_level+hysteresis, 2^(DATA_WIDTH−1)−1):
    - sat_seen: gain ← gain − max(gain>>2, 1) (fast attack).
    - else peak>hi: gain ← gain − step.
    - else peak<lo: gain ← gain + step.
    - else unchanged.
    - Gain is clamped to [1, 2^GAIN_WIDTH−1].
    - Then → MEASURE, clearing peak, cnt and sat_seen.
  - agc_enable=0 in any state → MANUAL next cycle; the partial window is discarded.
  - Pipeline stalls freeze cnt and peak; no input while idle leaves cnt unchanged.
  - The new gain applies to the first beat accepted at S1 after the ADJUST cycle.

Test Plan:
Defaults: DATA_WIDTH=16, GAIN_FRAC=8.
- Unity gain: manual_gain=256, shift=0, inputs 1000 and −1000 back-to-back with m_ready=1 → outputs 1000 and −1000 exactly 3 cycles after each accept; s_ready stays 1.
- Gain/shift/rounding: gain=384, shift=+1, input −1000 → −3000. Gain=256, shift=−2, input 1001 → 250 (1001/4 = 250.25, rounded). Input 1002 → 251 (250.5 rounds up).
- Saturation: gain=4095, inputs +20000 and −20000 → +32767 and −32767; sat_count=2. sat_clear pulse → sat_count=0.
- Backpressure: stream 20 ramp beats with m_ready low for 5 cycles mid-stream → s_ready falls within the same cycle; output is the exact ramp with no gaps or duplicates.
- AGC convergence: WIN_LOG2=4, target=8000, hysteresis=500, constant amplitude 2000, start gain 256 → gain rises by gain>>4 per 16-beat window and settles with output peak in [7500,8500]. Step input to 16000 → saturation triggers fast-attack decrement of gain>>2.
- Mode and reset mid-stream:
  - Drop agc_enable mid-window → gain_cur = manual_gain next cycle.
  - Assert rst_n low mid-stream → m_valid=0, sat_count=0 and gain_cur=256 immediately, with no clock edge required.

Source files
------------

// File: rtl/agc_gain_scaler.sv
// Purpose : per-channel fractional gain, signed power-of-two shift, round-half-up and symmetric
//           saturation, with an optional once-per-window peak-driven AGC loop.
// Latency : 3 cycles from s_valid&&s_ready to m_valid; 1 beat/cycle. Backpressure: m_ready low
//           with a valid output freezes all three stages and drops s_ready in the same cycle.
// Ports   : s_* input stream, m_* output stream, agc_enable/manual_gain/shift_ctrl/target_level/
//           hysteresis control, sat_clear clears sat_count, gain_cur is the gain applied at S1.
module agc_gain_scaler #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_CH     = 2,
    parameter int GAIN_WIDTH = 12,
    parameter int GAIN_FRAC  = 8,
    parameter int WIN_LOG2   = 10,
    parameter int AGC_STEP   = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_CH*DATA_WIDTH-1:0] s_data,
    input  logic                         s_valid,
    output logic                         s_ready,
    output logic [NUM_CH*DATA_WIDTH-1:0] m_data,
    output logic                         m_valid,
    input  logic                         m_ready,
    input  logic                         agc_enable,
    input  logic [GAIN_WIDTH-1:0]        manual_gain,
    input  logic [3:0]                   shift_ctrl,
    input  logic [DATA_WIDTH-2:0]        target_level,
    input  logic [DATA_WIDTH-2:0]        hysteresis,
    input  logic                         sat_clear,
    output logic [GAIN_WIDTH-1:0]        gain_cur,
    output logic [15:0]                  sat_count
);

    localparam int PW = DATA_WIDTH + GAIN_WIDTH + 1;   // product width
    localparam int WW = PW + 8;                        // room for a left shift of up to 8
    localparam int NW = 7;                             // signed net-shift width

    localparam logic [GAIN_WIDTH-1:0] UNITY   = GAIN_WIDTH'(1) << GAIN_FRAC;
    localparam logic [GAIN_WIDTH:0]   GMAX    = {1'b0, {GAIN_WIDTH{1'b1}}};
    localparam logic [DATA_WIDTH-2:0] MAG_MAX = {(DATA_WIDTH-1){1'b1}};
    localparam logic signed [WW-1:0]  SMAX    = {{(WW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [WW-1:0]  SMIN    = -SMAX;

    typedef enum logic [1:0] {ST_MANUAL, ST_MEASURE, ST_ADJUST} agc_st_e;

    // ---------------- pipeline state ----------------
    logic                         v1_q, v2_q, v3_q;
    logic [NUM_CH*DATA_WIDTH-1:0] d1_q, d3_q;
    logic [GAIN_WIDTH-1:0]        g1_q;
    logic [3:0]                   sh1_q, sh2_q;
    logic [NUM_CH*PW-1:0]         p2_q, p2_d;
    logic [NUM_CH*DATA_WIDTH-1:0] out_d;
    logic                         sat3_q, sat_d;
    logic                         en, out_acc;

    // ---------------- AGC / status state ----------------
    agc_st_e                      st_q, st_d;
    logic [GAIN_WIDTH-1:0]        gain_q, gain_d, gain_adj;
    logic [DATA_WIDTH-2:0]        peak_q, peak_d, beat_peak;
    logic [WIN_LOG2-1:0]          cnt_q, cnt_d;
    logic                         ssn_q, ssn_d;
    logic [15:0]                  satc_q, satc_d;

    assign en       = !v3_q || m_ready;
    assign s_ready  = en;
    assign m_valid  = v3_q;
    assign m_data   = d3_q;
    assign out_acc  = v3_q && m_ready;
    assign gain_cur = gain_q;
    assign sat_count = satc_q;

    // S2 product: sample times zero-extended gain, both sign-extended to PW first
    logic signed [PW-1:0] pa, pb;
    always_comb begin
        p2_d = '0;
        pa   = '0;
        pb   = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            pa = PW'($signed(d1_q[k*DATA_WIDTH +: DATA_WIDTH]));
            pb = PW'($signed({1'b0, g1_q}));
            p2_d[k*PW +: PW] = pa * pb;
        end
    end

    // S3 scaling: net = GAIN_FRAC - shift; right shifts round half up, left shifts are exact
    logic signed [NW-1:0] net;
    logic [NW-1:0]        rsh, lsh;
    logic signed [WW-1:0] ext, half, rnd;
    always_comb begin
        net   = NW'(GAIN_FRAC) - NW'($signed(sh2_q));
        rsh   = '0;
        lsh   = '0;
        if (net > 0) rsh = net;
        else         lsh = -net;
        out_d = '0;
        sat_d = 1'b0;
        ext   = '0;
        half  = '0;
        rnd   = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            ext  = WW'($signed(p2_q[k*PW +: PW]));
            half = '0;
            if (net > 0) begin
                half = WW'(1) << (rsh - NW'(1));
                rnd  = (ext + half) >>> rsh;
            end else begin
                rnd  = ext <<< lsh;
            end
            // symmetric clamp: the most negative code is never produced
            if (rnd > SMAX) begin
                rnd   = SMAX;
                sat_d = 1'b1;
            end else if (rnd < SMIN) begin
                rnd   = SMIN;
                sat_d = 1'b1;
            end
            out_d[k*DATA_WIDTH +: DATA_WIDTH] = rnd[DATA_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            v3_q   <= 1'b0;
            d1_q   <= '0;
            g1_q   <= '0;
            sh1_q  <= '0;
            p2_q   <= '0;
            sh2_q  <= '0;
            d3_q   <= '0;
            sat3_q <= 1'b0;
        end else if (en) begin
            v1_q <= s_valid;
            if (s_valid) begin
                d1_q  <= s_data;
                g1_q  <= gain_q;
                sh1_q <= shift_ctrl;
            end
            v2_q  <= v1_q;
            p2_q  <= p2_d;
            sh2_q <= sh1_q;
            v3_q  <= v2_q;
            if (v2_q) begin
                d3_q   <= out_d;
                sat3_q <= sat_d;
            end
        end
    end

    // Largest |channel| of the beat on the output; magnitude always fits DATA_WIDTH-1 bits
    logic signed [DATA_WIDTH-1:0] sv;
    logic [DATA_WIDTH-2:0]        mag;
    always_comb begin
        beat_peak = '0;
        sv        = '0;
        mag       = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            sv  = $signed(d3_q[k*DATA_WIDTH +: DATA_WIDTH]);
            mag = sv[DATA_WIDTH-1] ? (DATA_WIDTH-1)'(-sv) : sv[DATA_WIDTH-2:0];
            if (mag > beat_peak) beat_peak = mag;
        end
    end

    // Saturated-beat counter; a clear coinciding with a saturated accept leaves 1
    always_comb begin
        satc_d = satc_q;
        if (sat_clear) satc_d = (out_acc && sat3_q) ? 16'd1 : 16'd0;
        else if (out_acc && sat3_q && satc_q != 16'hFFFF) satc_d = satc_q + 16'd1;
    end

    // Gain update computed from the finished window
    logic [GAIN_WIDTH:0]   g_ext, step, fast, new_g;
    logic [DATA_WIDTH-1:0] thr_sum;
    logic [DATA_WIDTH-2:0] lo, hi;
    always_comb begin
        g_ext   = {1'b0, gain_q};
        step    = {1'b0, gain_q >> AGC_STEP};
        fast    = {1'b0, gain_q >> 2};
        if (step == '0) step = 1;
        if (fast == '0) fast = 1;
        thr_sum = {1'b0, target_level} + {1'b0, hysteresis};
        hi      = (thr_sum > {1'b0, MAG_MAX}) ? MAG_MAX : thr_sum[DATA_WIDTH-2:0];
        lo      = (target_level > hysteresis) ? target_level - hysteresis : '0;
        if (ssn_q)           new_g = (g_ext > fast) ? g_ext - fast : '0;
        else if (peak_q > hi) new_g = (g_ext > step) ? g_ext - step : '0;
        else if (peak_q < lo) new_g = g_ext + step;
        else                  new_g = g_ext;
        if (new_g == '0)  new_g = 1;
        if (new_g > GMAX) new_g = GMAX;
        gain_adj = new_g[GAIN_WIDTH-1:0];
    end

    always_comb begin
        st_d   = st_q;
        gain_d = gain_q;
        peak_d = peak_q;
        cnt_d  = cnt_q;
        ssn_d  = ssn_q;
        if (!agc_enable) begin
            // leaving AGC discards the partial window
            st_d   = ST_MANUAL;
            gain_d = manual_gain;
            peak_d = '0;
            cnt_d  = '0;
            ssn_d  = 1'b0;
        end else begin
            case (st_q)
                ST_MANUAL: begin
                    st_d   = ST_MEASURE;
                    peak_d = '0;
                    cnt_d  = '0;
                    ssn_d  = 1'b0;
                end
                ST_MEASURE: begin
                    if (out_acc) begin
                        peak_d = (beat_peak > peak_q) ? beat_peak : peak_q;
                        ssn_d  = ssn_q | sat3_q;
                        cnt_d  = cnt_q + 1'b1;
                        if (cnt_q == '1) st_d = ST_ADJUST;
                    end
                end
                ST_ADJUST: begin
                    gain_d = gain_adj;
                    st_d   = ST_MEASURE;
                    peak_d = '0;
                    cnt_d  = '0;
                    ssn_d  = 1'b0;
                end
                default: st_d = ST_MANUAL;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q   <= ST_MANUAL;
            gain_q <= UNITY;
            peak_q <= '0;
            cnt_q  <= '0;
            ssn_q  <= 1'b0;
            satc_q <= '0;
        end else begin
            st_q   <= st_d;
            gain_q <= gain_d;
            peak_q <= peak_d;
            cnt_q  <= cnt_d;
            ssn_q  <= ssn_d;
            satc_q <= satc_d;
        end
    end

endmodule

// File: tb/tb_agc_gain_scaler.sv
// Purpose : directed checks of agc_gain_scaler: reset, scaling/rounding, saturation, stalls, AGC.
// Latency : expects outputs 3 cycles after each accepted input.
// Backpressure: drives m_ready low mid-stream and checks the captured output order.
module tb_agc_gain_scaler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic        agc_enable = 1'b0;
    logic [11:0] manual_gain = 12'd256;
    logic [3:0]  shift_ctrl = 4'd0;
    logic [14:0] target_level = '0;
    logic [14:0] hysteresis = '0;
    logic        sat_clear = 1'b0;
    logic [11:0] gain_cur;
    logic [15:0] sat_count;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] out_q[$];

    always #5 clk = ~clk;

    agc_gain_scaler #(.WIN_LOG2(4)) dut (
        .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .agc_enable(agc_enable),
        .manual_gain(manual_gain), .shift_ctrl(shift_ctrl), .target_level(target_level),
        .hysteresis(hysteresis), .sat_clear(sat_clear), .gain_cur(gain_cur), .sat_count(sat_count)
    );

    // capture every accepted output beat, sampled mid-cycle
    always @(negedge clk) if (m_valid && m_ready) out_q.push_back(m_data);

    task automatic check(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int ch(input logic [31:0] d, input int k);
        logic [15:0] w;
        w = d[k*16 +: 16];
        return int'($signed(w));
    endfunction

    function automatic logic [31:0] pack2(input int c0, input int c1);
        return {16'(c1), 16'(c0)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_one(input string tag, input int g, input int sh,
                            input int a0, input int a1, input int e0, input int e1);
        manual_gain = 12'(g);
        shift_ctrl  = 4'(sh);
        tick();
        tick();
        check({tag, "_gain"}, gain_cur, g);
        s_data  = pack2(a0, a1);
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        tick();
        check({tag, "_early"}, m_valid, 0);
        tick();
        check({tag, "_vld"}, m_valid, 1);
        check({tag, "_ch0"}, ch(m_data, 0), e0);
        check({tag, "_ch1"}, ch(m_data, 1), e1);
        tick();
    endtask

    initial begin
        int cyc, i, w;
        logic acc;

        #3 rst_n = 1'b0;
        #1;
        check("rst_mvalid", m_valid, 0);
        check("rst_mdata", m_data, 0);
        check("rst_satcnt", sat_count, 0);
        check("rst_gain", gain_cur, 256);
        check("rst_sready", s_ready, 1);
        #20;
        @(posedge clk);
        #2 rst_n = 1'b1;
        tick();

        // unity gain, two back-to-back beats
        s_data  = pack2(1000, -1000);
        s_valid = 1'b1;
        check("uni_srdy0", s_ready, 1);
        tick();
        s_data = pack2(-1000, 1000);
        check("uni_srdy1", s_ready, 1);
        tick();
        s_valid     = 1'b0;
        manual_gain = 12'd512;      // must not touch beats already in flight
        check("uni_lat2", m_valid, 0);
        tick();
        check("uni_a_vld", m_valid, 1);
        check("uni_a_ch0", ch(m_data, 0), 1000);
        check("uni_a_ch1", ch(m_data, 1), -1000);
        tick();
        check("uni_b_vld", m_valid, 1);
        check("uni_b_ch0", ch(m_data, 0), -1000);
        check("uni_b_ch1", ch(m_data, 1), 1000);
        tick();
        check("uni_end", m_valid, 0);

        send_one("g384", 384, 1, -1000, 1000, -3000, 3000);
        send_one("rnd", 256, -2, 1001, 1002, 250, 251);
        send_one("rndn", 256, -2, -1002, -1001, -250, -250);
        send_one("shl7", 256, 7, 100, -100, 12800, -12800);
        send_one("shr8", 256, -8, 1000, -1000, 4, -4);
        check("nosat_cnt", sat_count, 0);
        send_one("sat_p", 4095, 0, 20000, 0, 32767, 0);
        send_one("sat_n", 4095, 0, -20000, 0, -32767, 0);
        check("sat_cnt2", sat_count, 2);
        sat_clear = 1'b1;
        tick();
        sat_clear = 1'b0;
        check("sat_clr", sat_count, 0);
        send_one("minneg", 256, 0, -32768, 32767, -32767, 32767);
        check("minneg_cnt", sat_count, 1);

        // backpressure: 20-beat ramp, m_ready low for cycles 8..12
        out_q.delete();
        cyc = 0;
        i   = 0;
        while (i < 20 && cyc < 200) begin
            m_ready = !(cyc >= 8 && cyc < 13);
            s_valid = 1'b1;
            s_data  = pack2(i*100 + 1, -(i*100 + 7));
            #1;
            if (cyc == 8)  check("bp_srdy_low", s_ready, 0);
            if (cyc == 13) check("bp_srdy_high", s_ready, 1);
            acc = s_ready;
            @(posedge clk);
            #1;
            if (acc) i++;
            cyc++;
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        repeat (6) tick();
        check("bp_sent", i, 20);
        check("bp_count", out_q.size(), 20);
        for (int j = 0; j < 20; j++) begin
            if (j < out_q.size()) check($sformatf("bp_beat%0d", j), out_q[j], pack2(j*100 + 1, -(j*100 + 7)));
        end

        // AGC convergence from unity towards a 2000 -> ~8000 peak
        manual_gain  = 12'd256;
        shift_ctrl   = 4'd0;
        target_level = 15'd8000;
        hysteresis   = 15'd500;
        tick();
        tick();
        check("agc_start_gain", gain_cur, 256);
        s_data     = pack2(2000, -2000);
        s_valid    = 1'b1;
        agc_enable = 1'b1;
        w = 0;
        while (gain_cur == 12'd256 && w < 200) begin tick(); w++; end
        check("agc_first_step", gain_cur, 272);
        repeat (1000) tick();
        check("agc_settled_gain", gain_cur, 1012);
        check("agc_out_vld", m_valid, 1);
        check("agc_out_ch0", ch(m_data, 0), 7906);
        check("agc_out_ch1", ch(m_data, 1), -7906);

        // step to 16000 saturates; fast attack removes a quarter of the gain
        s_data = pack2(16000, -16000);
        w = 0;
        while (gain_cur == 12'd1012 && w < 100) begin tick(); w++; end
        check("agc_fast_attack", gain_cur, 759);

        repeat (5) tick();
        manual_gain = 12'd300;
        agc_enable  = 1'b0;
        tick();
        check("agc_off_gain", gain_cur, 300);

        // asynchronous reset mid-stream
        check("pre_rst_vld", m_valid, 1);
        check("pre_rst_satnz", (sat_count != 0), 1);
        rst_n = 1'b0;
        #1;
        check("arst_mvalid", m_valid, 0);
        check("arst_satcnt", sat_count, 0);
        check("arst_gain", gain_cur, 256);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
